block_draw_controller: RTL and testbench
========================================

# block_draw_controller

Sequences frame-buffer writes for the stacking game. On each `sync` frame tick it turns the game-logic position and status into a stream of single-pixel plots for the VGA adapter:
- clear the screen after reset;
- erase the moving block's previous rectangle;
- draw the new rectangle;
- flood the screen on game over.

It sits between the game-logic top level (x, y, game_status) and the VGA adapter plot port. It is the only writer to that port.

## Interface
Parameters:
- BLOCK_W, 16, block width in pixels
- BLOCK_H, 4, block height in pixels
- SCREEN_W, 160, screen width
- SCREEN_H, 120, screen height
- BG_COLOUR, 3'b000, background/erase colour
- BLOCK_COLOUR, 3'b111, moving-block colour
- OVER_COLOUR, 3'b100, game-over fill colour

Ports:
- clk  in  1  system clock (50 MHz); the block has one clock.
- resetn  in  1  reset; synchronous, active-low.
- sync  in  1  one-cycle frame tick.
- x  in  8  block left column.
- y  in  7  block top row.
- game_status  in  2  game status: 00 IDLE, 01 PLAY, 10 OVER, 11 treated as IDLE.
- vga_x  out  8  pixel column.
- vga_y  out  7  pixel row.
- colour  out  3  pixel colour.
- plot  out  1  write strobe for the current vga_x, vga_y, colour.
- busy  out  1  high while a pixel sequence is in progress.

## Operation
States:
- CLEAR: scans the full screen row-major, x fastest, colour BG_COLOUR. Then goes to WAIT. Clears `have_old` and `over_done`.
- WAIT: idle; sync is sampled only here.
  - sync with PLAY: latch x, y into `new_x`/`new_y`.
    - If `over_done`=1: go to CLEAR, then to DRAW with the latched coordinates.
    - Else if `have_old`=1 and `new_y`==`old_y`: go to ERASE.
    - Otherwise go to DRAW. A changed y means the old block has landed and stays on screen as part of the tower.
  - sync with OVER and `over_done`=0: go to FILL.
  - sync with IDLE, or OVER with `over_done`=1: no action.
- ERASE: scans BLOCK_W×BLOCK_H at (`old_x`, `old_y`) with BG_COLOUR, then goes to DRAW.
- DRAW: scans the rectangle at (`new_x`, `new_y`) with BLOCK_COLOUR. On completion: `old`←`new`, `have_old`←1, go to WAIT.
- FILL: full-screen scan with OVER_COLOUR. Sets `over_done`=1 and `have_old`=0, then goes to WAIT.

Arithmetic and boundaries:
- Rectangle pixel = base + offset. Compute it 9 bits wide for x and 8 bits wide for y.
- If the pixel is off-screen (≥ SCREEN_W or ≥ SCREEN_H), hold plot=0 for that cycle. The scan still spends the cycle, so sequence length is fixed and there is no wrap-around.
- sync arriving while busy=1 is dropped; there is no queuing.
- x and y are sampled only on the accepted sync cycle. Changes mid-sequence are ignored.
- Reset mid-sequence abandons the scan immediately; there is no partial-state recovery.

## Timing
- While resetn=0: vga_x=0, vga_y=0, colour=0, plot=0, busy=0, state=CLEAR with counters at 0, `have_old`=0, `over_done`=0.
- The first CLEAR pixel (0,0) is presented with plot=1 the first cycle resetn=1.
- All outputs are registered. One pixel per cycle.
- A sync accepted at cycle T puts the first pixel on the outputs at T+1.
- Sequence lengths:
  - ERASE and DRAW: BLOCK_W·BLOCK_H cycles each (64 with defaults).
  - CLEAR and FILL: SCREEN_W·SCREEN_H cycles (19200 with defaults).
- busy=1 on every cycle that presents a sequence pixel. It falls the cycle after the last pixel, when the state is WAIT.
- The earliest next sync accepted is that WAIT cycle.
- ERASE→DRAW and CLEAR→DRAW are back-to-back with no gap cycle.

## Structure
- Shared package `draw_pkg`:
  - status codes (ST_IDLE, ST_PLAY, ST_OVER);
  - state enum;
  - SCREEN_W/SCREEN_H constants;
  - colour constants.
- Sub-module `rect_scanner`:
  - inputs: start, base x/y, width, height;
  - behaviour: produces row-major offsets, an on-screen flag and a `last` pulse;
  - reused for both full-screen and block scans (base 0, size SCREEN_W×SCREEN_H).
- The controller FSM and the old/new coordinate registers live in `block_draw_controller`.

## Test plan
- Release reset → 19200 consecutive plot=1 cycles with colour=000, first (0,0), last (159,119); busy drops the next cycle.
- After the clear, sync PLAY with x=10, y=100 → 64 plots colour=111 covering x 10..25, y 100..103; no erase pixels.
- Then sync PLAY with x=12, y=100 → 64 plots colour=000 at x 10..25, then 64 plots colour=111 at x 12..27; busy for exactly 128 cycles. A second sync pulsed 20 cycles in is ignored.
- Then sync PLAY with x=12, y=96 → no erase; 64 plots colour=111 at y 96..99; rows 100..103 are untouched.
- sync PLAY with x=150, y=118 → busy for 64 cycles, plot=1 on only 20 of them (x 150..159, y 118..119).
- sync OVER → 19200 plots colour=100. A second OVER sync does nothing. A later PLAY sync → 19200-cycle clear, then a 64-cycle draw. Asserting resetn=0 mid-fill → plot=0 next cycle; the clear restarts at (0,0) after release.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the block draw controller.
//   - game status codes as seen on game_status
//   - controller state encoding
//   - default screen geometry and colours
package draw_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_WAIT,
    S_ERASE,
    S_DRAW,
    S_FILL
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BG    = 3'b000;
  localparam logic [2:0] COL_BLOCK = 3'b111;
  localparam logic [2:0] COL_OVER  = 3'b100;

endpackage

// File: rtl/block_draw_controller_if.sv
// Game-logic inputs and VGA plot port of the block draw controller.
//   sync, x, y, game_status : from game logic to the controller
//   vga_x, vga_y, colour, plot, busy : from the controller to the VGA adapter
// master = the controller, slave = the game logic / VGA side.
interface block_draw_controller_if;
  logic       sync;
  logic [7:0] x;
  logic [6:0] y;
  logic [1:0] game_status;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  modport master (
    input  sync, x, y, game_status,
    output vga_x, vga_y, colour, plot, busy
  );

  modport slave (
    output sync, x, y, game_status,
    input  vga_x, vga_y, colour, plot, busy
  );
endinterface

// File: rtl/block_draw_controller_rect_scanner.sv
// Row-major rectangle scanner, x fastest.
//   clk, resetn     : clock, synchronous active-low reset
//   start           : present offset (0,0) this cycle, ignoring the counters
//   active          : a scan is in progress; advance past the current offset
//   base_x/base_y   : rectangle origin
//   width/height    : rectangle size in pixels
//   pix_x/pix_y     : current pixel (valid only when on_screen)
//   on_screen       : current pixel lies inside the screen
//   last            : current offset is the final one of the rectangle
module rect_scanner #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       active,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [7:0] width,
  input  logic [6:0] height,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic       on_screen,
  output logic       last
);

  logic [7:0] off_x_q, off_x_d, cur_x;
  logic [6:0] off_y_q, off_y_d, cur_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       row_end;

  always_comb begin
    cur_x = start ? 8'd0 : off_x_q;
    cur_y = start ? 7'd0 : off_y_q;
    // One extra bit so a block hanging off the right/bottom edge is
    // detected instead of wrapping to the other side.
    sum_x = {1'b0, base_x} + {1'b0, cur_x};
    sum_y = {1'b0, base_y} + {1'b0, cur_y};
    pix_x = sum_x[7:0];
    pix_y = sum_y[6:0];
    on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    row_end = (cur_x == width - 8'd1);
    last = row_end && (cur_y == height - 7'd1);

    off_x_d = off_x_q;
    off_y_d = off_y_q;
    if (start || active) begin
      if (row_end) begin
        off_x_d = 8'd0;
        off_y_d = last ? 7'd0 : cur_y + 7'd1;
      end else begin
        off_x_d = cur_x + 8'd1;
        off_y_d = cur_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      off_x_q <= 8'd0;
      off_y_q <= 7'd0;
    end else begin
      off_x_q <= off_x_d;
      off_y_q <= off_y_d;
    end
  end

endmodule

// File: rtl/block_draw_controller.sv
// Frame-buffer write sequencer for the stacking game.
//   clk, resetn : clock, synchronous active-low reset
//   bus (master): sync/x/y/game_status in, vga_x/vga_y/colour/plot/busy out
// Each accepted sync starts a pixel sequence (clear, erase+draw, draw, fill)
// emitted one pixel per cycle on registered outputs.
module block_draw_controller
  import draw_pkg::*;
#(
  parameter int         BLOCK_W      = 16,
  parameter int         BLOCK_H      = 4,
  parameter int         SCREEN_W     = draw_pkg::SCREEN_W,
  parameter int         SCREEN_H     = draw_pkg::SCREEN_H,
  parameter logic [2:0] BG_COLOUR    = COL_BG,
  parameter logic [2:0] BLOCK_COLOUR = COL_BLOCK,
  parameter logic [2:0] OVER_COLOUR  = COL_OVER
) (
  input logic                     clk,
  input logic                     resetn,
  block_draw_controller_if.master bus
);

  state_t     state_q, state_d, tgt, emit_state;
  logic [7:0] new_x_q, new_x_d, old_x_q, old_x_d;
  logic [6:0] new_y_q, new_y_d, old_y_q, old_y_d;
  logic       have_old_q, have_old_d, over_done_q, over_done_d;
  logic       pend_draw_q, pend_draw_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d;

  logic       start, emitting;
  logic [7:0] scan_bx, scan_w, pix_x;
  logic [6:0] scan_by, scan_h, pix_y;
  logic       on_screen, last;

  // Command decode. An accepted sync emits the first pixel of its sequence
  // on the same edge, so the scanner is started combinationally.
  always_comb begin
    start   = 1'b0;
    tgt     = S_WAIT;
    new_x_d = new_x_q;
    new_y_d = new_y_q;
    if (state_q == S_WAIT && bus.sync) begin
      if (bus.game_status == ST_PLAY) begin
        start   = 1'b1;
        new_x_d = bus.x;
        new_y_d = bus.y;
        if (over_done_q)
          tgt = S_CLEAR;            // wipe the game-over screen, then draw
        else if (have_old_q && bus.y == old_y_q)
          tgt = S_ERASE;
        else
          tgt = S_DRAW;             // new row: the old block stays as tower
      end else if (bus.game_status == ST_OVER && !over_done_q) begin
        start = 1'b1;
        tgt   = S_FILL;
      end
    end
    emit_state = start ? tgt : state_q;
    emitting   = (emit_state != S_WAIT);

    case (emit_state)
      S_ERASE: begin
        scan_bx = old_x_q;  scan_by = old_y_q;
        scan_w  = 8'(BLOCK_W); scan_h = 7'(BLOCK_H);
      end
      S_DRAW: begin
        scan_bx = new_x_d;  scan_by = new_y_d;
        scan_w  = 8'(BLOCK_W); scan_h = 7'(BLOCK_H);
      end
      default: begin
        scan_bx = 8'd0;     scan_by = 7'd0;
        scan_w  = 8'(SCREEN_W); scan_h = 7'(SCREEN_H);
      end
    endcase
  end

  rect_scanner #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_scan (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .active    (state_q != S_WAIT),
    .base_x    (scan_bx),
    .base_y    (scan_by),
    .width     (scan_w),
    .height    (scan_h),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .on_screen (on_screen),
    .last      (last)
  );

  always_comb begin
    state_d     = emit_state;
    old_x_d     = old_x_q;
    old_y_d     = old_y_q;
    have_old_d  = have_old_q;
    over_done_d = over_done_q;
    pend_draw_d = pend_draw_q;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    busy_d      = 1'b0;

    if (start && tgt == S_CLEAR) pend_draw_d = 1'b1;

    if (emitting) begin
      vga_x_d = pix_x;
      vga_y_d = pix_y;
      plot_d  = on_screen;          // off-screen pixels still cost a cycle
      busy_d  = 1'b1;
      case (emit_state)
        S_DRAW:  colour_d = BLOCK_COLOUR;
        S_FILL:  colour_d = OVER_COLOUR;
        default: colour_d = BG_COLOUR;
      endcase
      if (last) begin
        case (emit_state)
          S_CLEAR: begin
            have_old_d  = 1'b0;
            over_done_d = 1'b0;
            pend_draw_d = 1'b0;
            state_d     = pend_draw_q ? S_DRAW : S_WAIT;
          end
          S_ERASE: state_d = S_DRAW;
          S_DRAW: begin
            old_x_d    = new_x_d;
            old_y_d    = new_y_d;
            have_old_d = 1'b1;
            state_d    = S_WAIT;
          end
          default: begin            // S_FILL
            over_done_d = 1'b1;
            have_old_d  = 1'b0;
            state_d     = S_WAIT;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_CLEAR;
      new_x_q     <= 8'd0;
      new_y_q     <= 7'd0;
      old_x_q     <= 8'd0;
      old_y_q     <= 7'd0;
      have_old_q  <= 1'b0;
      over_done_q <= 1'b0;
      pend_draw_q <= 1'b0;
      vga_x_q     <= 8'd0;
      vga_y_q     <= 7'd0;
      colour_q    <= 3'd0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      new_x_q     <= new_x_d;
      new_y_q     <= new_y_d;
      old_x_q     <= old_x_d;
      old_y_q     <= old_y_d;
      have_old_q  <= have_old_d;
      over_done_q <= over_done_d;
      pend_draw_q <= pend_draw_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.vga_x  = vga_x_q;
  assign bus.vga_y  = vga_y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_block_draw_controller.sv
`timescale 1ns/1ps
module tb_block_draw_controller;
  import draw_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #10 clk = ~clk;

  block_draw_controller_if bus();

  block_draw_controller dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [17:0] exp_q[$];            // {x[7:0], y[6:0], colour[2:0]} in plot order
  bit          mon_en = 1'b0;

  // Reference model: what is on screen from the game's point of view.
  bit m_have_old, m_over_done;
  int m_old_x, m_old_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
      if (bad >= 50) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  // Queue the visible pixels of a rectangle; returns cycles spent scanning it.
  function automatic int push_rect(int bx, int by, int w, int h, logic [2:0] col);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (bx + c < 160 && by + r < 120)
          exp_q.push_back({8'(bx + c), 7'(by + r), col});
    return w * h;
  endfunction

  function automatic int model_cmd(logic [1:0] st, int nx, int ny);
    int len = 0;
    if (st == ST_PLAY) begin
      if (m_over_done) begin
        len += push_rect(0, 0, 160, 120, 3'b000);
        m_over_done = 1'b0;
        m_have_old  = 1'b0;
      end else if (m_have_old && ny == m_old_y) begin
        len += push_rect(m_old_x, m_old_y, 16, 4, 3'b000);
      end
      len += push_rect(nx, ny, 16, 4, 3'b111);
      m_old_x = nx;
      m_old_y = ny;
      m_have_old = 1'b1;
    end else if (st == ST_OVER && !m_over_done) begin
      len += push_rect(0, 0, 160, 120, 3'b100);
      m_over_done = 1'b1;
      m_have_old  = 1'b0;
    end
    return len;
  endfunction

  // Monitor: every plot strobe must match the next expected pixel.
  always @(negedge clk) begin
    if (mon_en && bus.plot === 1'b1) begin
      if (exp_q.size() == 0)
        chk("extra_plot", {14'd0, bus.vga_x, bus.vga_y, bus.colour}, 32'h3ffff);
      else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("pixel", {14'd0, bus.vga_x, bus.vga_y, bus.colour}, {14'd0, e});
      end
    end
  end

  // Count consecutive busy cycles starting at the next negedge; optionally
  // pulse a sync (with fresh coordinates) mid-sequence, which must be dropped.
  task automatic wait_busy(input int exp_len, input bit drop, input string name);
    int n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 25000) begin
      n++;
      if (drop && n == 20) begin
        bus.sync = 1'b1;
        bus.game_status = ST_PLAY;
        bus.x = 8'($urandom);
        bus.y = 7'($urandom);
      end else
        bus.sync = 1'b0;
      @(negedge clk);
    end
    bus.sync = 1'b0;
    chk(name, n, exp_len);
    $display("cmd %s busy_cycles=%0d expected=%0d", name, n, exp_len);
  endtask

  // Issue one sync from a WAIT cycle (caller is at a negedge with busy=0).
  task automatic issue(input logic [1:0] st, input int nx, input int ny,
                       input bit drop, input string name);
    int len;
    len = model_cmd(st, nx, ny);
    bus.sync = 1'b1;
    bus.game_status = st;
    bus.x = 8'(nx);
    bus.y = 7'(ny);
    @(posedge clk);
    #1;
    bus.sync = 1'b0;
    bus.x = 8'($urandom);           // must be ignored after acceptance
    bus.y = 7'($urandom);
    wait_busy(len, drop, name);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nx, ny;
    logic [1:0] st;

    resetn = 1'b0;
    bus.sync = 1'b0;
    bus.x = 8'd0;
    bus.y = 7'd0;
    bus.game_status = ST_IDLE;
    m_have_old = 1'b0;
    m_over_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_plot",   bus.plot,   0);
    chk("rst_busy",   bus.busy,   0);
    chk("rst_vga_x",  bus.vga_x,  0);
    chk("rst_vga_y",  bus.vga_y,  0);
    chk("rst_colour", bus.colour, 0);

    void'(push_rect(0, 0, 160, 120, 3'b000));
    mon_en = 1'b1;
    resetn = 1'b1;
    wait_busy(19200, 1'b0, "initial_clear");

    issue(ST_PLAY, 10, 100, 1'b0, "draw_10_100");
    issue(ST_PLAY, 12, 100, 1'b1, "erase_draw_12_100");
    issue(ST_PLAY, 12, 96,  1'b0, "land_draw_12_96");
    issue(ST_PLAY, 150, 118, 1'b0, "edge_draw_150_118");
    issue(ST_OVER, 0, 0,    1'b0, "fill_over");
    issue(ST_OVER, 0, 0,    1'b0, "second_over_ignored");
    issue(ST_IDLE, 5, 5,    1'b0, "idle_ignored");
    issue(2'b11,   5, 5,    1'b0, "status3_ignored");
    issue(ST_PLAY, 30, 50,  1'b0, "clear_then_draw");

    for (int i = 0; i < 20; i++) begin
      st = ($urandom_range(0, 5) == 0) ? 2'(2'b11 * $urandom_range(0, 1)) : ST_PLAY;
      nx = $urandom_range(0, 255);
      ny = (m_have_old && $urandom_range(0, 1) == 1) ? m_old_y : $urandom_range(0, 127);
      issue(st, nx, ny, 1'($urandom_range(0, 1)), "random_cmd");
    end

    // Reset in the middle of a fill, then the clear must restart at (0,0).
    void'(model_cmd(ST_OVER, 0, 0));
    bus.sync = 1'b1;
    bus.game_status = ST_OVER;
    @(posedge clk);
    #1;
    bus.sync = 1'b0;
    repeat (500) @(negedge clk);
    chk("fill_midway_busy", bus.busy, 1);
    mon_en = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midreset_plot", bus.plot, 0);
    chk("midreset_busy", bus.busy, 0);
    exp_q.delete();
    m_have_old = 1'b0;
    m_over_done = 1'b0;
    void'(push_rect(0, 0, 160, 120, 3'b000));
    mon_en = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    wait_busy(19200, 1'b0, "clear_after_reset");
    issue(ST_PLAY, 40, 60, 1'b0, "draw_after_reset");

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
